// File: rtl/fir_decimator.sv
// ---------------------------------------------------------------------------
// fir_decimator
//
// Decimator stage behind the hsFIR filter. It keeps one sample out of every
// DECIM valid input samples (the one at index PHASE within the group). Kept
// samples go into a small FIFO, which the next consumer reads through a
// valid/ready handshake. A kept sample that finds the FIFO full, with no pop
// freeing a slot in the same cycle, is discarded. Such a drop sets a sticky
// overflow flag.
//
// Parameters:
//   DATA_W     - sample width in bits
//   DECIM      - decimation factor (1..16, 1 = pass-through with buffering)
//   PHASE      - index of the kept sample within a DECIM group (0..DECIM-1)
//   FIFO_DEPTH - FIFO entries (power of 2, >= 2)
//
// Ports:
//   i_clk      in   system clock, rising edge
//   i_reset_n  in   synchronous active-low reset
//   i_data     in   DATA_W sample from hsFIR
//   i_valid    in   i_data carries a new sample this cycle
//   o_data     out  DATA_W FIFO head (0 while the FIFO is empty)
//   o_valid    out  o_data holds a valid sample
//   i_ready    in   downstream accepts o_data this cycle
//   o_level    out  FIFO occupancy, clog2(FIFO_DEPTH)+1 bits
//   o_overflow out  sticky: a kept sample was dropped since reset
// ---------------------------------------------------------------------------
module fir_decimator #(
   parameter int DATA_W     = 8,
   parameter int DECIM      = 2,
   parameter int PHASE      = 0,
   parameter int FIFO_DEPTH = 4,
   localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [LVL_W-1:0]  o_level,
   output logic              o_overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   // The counter needs at least one bit. With DECIM=1 it stays at 0, so
   // every valid sample matches PHASE=0.
   localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

   logic [CNT_W-1:0]  phase_cnt;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  level;
   logic              overflow;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];

   logic keep;
   logic full;
   logic pop;
   logic push;
   logic drop;

   always_comb begin
      keep = i_valid && (phase_cnt == CNT_W'(PHASE));
      full = (level == LVL_W'(FIFO_DEPTH));
      // Pop requires a non-empty FIFO, so i_ready is ignored while empty.
      pop  = (level != '0) && i_ready;
      // When the FIFO is full, a pop in the same cycle frees the slot that
      // the write uses.
      push = keep && (!full || pop);
      drop = keep && full && !pop;
   end

   // Control state: phase counter, pointers, occupancy, sticky overflow
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         phase_cnt <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         overflow  <= 1'b0;
      end else begin
         if (i_valid) begin
            if (phase_cnt == CNT_W'(DECIM - 1))
               phase_cnt <= '0;
            else
               phase_cnt <= phase_cnt + CNT_W'(1);
         end

         // Pointers wrap for free because FIFO_DEPTH is a power of 2.
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);

         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase

         if (drop)
            overflow <= 1'b1;
      end
   end

   // Storage: data only, no reset. Stale entries are never visible,
   // because o_data is masked whenever the level is 0.
   always_ff @(posedge i_clk) begin
      if (push)
         mem[wr_ptr] <= i_data;
   end

   always_comb begin
      o_valid    = (level != '0);
      o_data     = o_valid ? mem[rd_ptr] : '0;
      o_level    = level;
      o_overflow = overflow;
   end

endmodule

// File: tb/tb_fir_decimator.sv
// Bench for fir_decimator. It drives two instances:
// A uses DECIM=2, PHASE=0, depth 4. B uses DECIM=3, PHASE=2, depth 4.
// A queue-based model of each instance is checked on every falling edge.
// Directed scenarios add hand-computed literal expectations.
module tb_fir_decimator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [7:0] a_din, b_din, a_dout, b_dout;
   logic       a_vld, b_vld, a_rdy, b_rdy;
   logic       a_ov, b_ov, a_of, b_of;
   logic [2:0] a_lvl, b_lvl;

   fir_decimator #(.DATA_W(8), .DECIM(2), .PHASE(0), .FIFO_DEPTH(4)) dut_a (
      .i_clk(clk), .i_reset_n(rst_n), .i_data(a_din), .i_valid(a_vld),
      .o_data(a_dout), .o_valid(a_ov), .i_ready(a_rdy), .o_level(a_lvl),
      .o_overflow(a_of));

   fir_decimator #(.DATA_W(8), .DECIM(3), .PHASE(2), .FIFO_DEPTH(4)) dut_b (
      .i_clk(clk), .i_reset_n(rst_n), .i_data(b_din), .i_valid(b_vld),
      .o_data(b_dout), .o_valid(b_ov), .i_ready(b_rdy), .o_level(b_lvl),
      .o_overflow(b_of));

   int checks = 0;
   int passes = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // Model: count valid samples since reset, keep index%DECIM==PHASE,
   // hold kept samples in a queue bounded at 4 entries.
   logic [7:0] qa[$], qb[$];
   int ia = 0, ib = 0;
   bit ofa = 1'b0, ofb = 1'b0;

   always @(posedge clk) begin
      bit full, pop, keep;
      if (!rst_n) begin
         qa.delete(); ia = 0; ofa = 1'b0;
      end else begin
         full = (qa.size() == 4);
         pop  = (qa.size() != 0) && a_rdy;
         keep = a_vld && ((ia % 2) == 0);
         if (a_vld) ia++;
         if (pop) void'(qa.pop_front());
         if (keep) begin
            if (!full || pop) qa.push_back(a_din);
            else ofa = 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      bit full, pop, keep;
      if (!rst_n) begin
         qb.delete(); ib = 0; ofb = 1'b0;
      end else begin
         full = (qb.size() == 4);
         pop  = (qb.size() != 0) && b_rdy;
         keep = b_vld && ((ib % 3) == 2);
         if (b_vld) ib++;
         if (pop) void'(qb.pop_front());
         if (keep) begin
            if (!full || pop) qb.push_back(b_din);
            else ofb = 1'b1;
         end
      end
   end

   // Per-cycle compare, plus a log of the samples actually handed downstream.
   logic [7:0] loga[$], logb[$];

   always @(negedge clk) begin
      if (chk_en) begin
         chk("a_valid", a_ov, qa.size() != 0);
         chk("a_data", a_dout, (qa.size() != 0) ? qa[0] : 8'h00);
         chk("a_level", a_lvl, qa.size());
         chk("a_ovf", a_of, ofa);
         chk("b_valid", b_ov, qb.size() != 0);
         chk("b_data", b_dout, (qb.size() != 0) ? qb[0] : 8'h00);
         chk("b_level", b_lvl, qb.size());
         chk("b_ovf", b_of, ofb);
         if (rst_n && a_ov && a_rdy) loga.push_back(a_dout);
         if (rst_n && b_ov && b_rdy) logb.push_back(b_dout);
      end
   end

   task automatic senda(input logic v, input logic [7:0] d, input logic r);
      a_vld = v; a_din = d; a_rdy = r;
      @(posedge clk); #1;
   endtask

   task automatic sendb(input logic v, input logic [7:0] d, input logic r);
      b_vld = v; b_din = d; b_rdy = r;
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   int peak;
   logic [7:0] exp4 [4];
   logic [7:0] exp5 [5];

   initial begin
      rst_n = 1'b0;
      a_vld = 1'b1; a_din = 8'hAA; a_rdy = 1'b0;
      b_vld = 1'b1; b_din = 8'hAA; b_rdy = 1'b0;

      // Reset held 3 cycles with valid input present
      repeat (3) begin
         @(posedge clk); #1;
         chk("rst_valid", a_ov, 1'b0);
         chk("rst_data", a_dout, 8'h00);
         chk("rst_level", a_lvl, 3'd0);
         chk("rst_ovf", a_of, 1'b0);
         chk_en = 1'b1;
      end
      rst_n = 1'b1; a_vld = 1'b0; b_vld = 1'b0;
      @(posedge clk); #1;

      // Basic decimation on A
      loga.delete(); peak = 0;
      for (int k = 0; k < 4; k++) begin
         senda(1'b1, 8'h10 + 8'(k), 1'b1);
         if (k == 0) begin
            chk("lat_valid", a_ov, 1'b1);
            chk("lat_data", a_dout, 8'h10);
         end
         if (int'(a_lvl) > peak) peak = int'(a_lvl);
      end
      repeat (3) begin
         senda(1'b0, 8'h00, 1'b1);
         if (int'(a_lvl) > peak) peak = int'(a_lvl);
      end
      chk("basic_count", loga.size(), 2);
      if (loga.size() == 2) begin
         chk("basic_out0", loga[0], 8'h10);
         chk("basic_out1", loga[1], 8'h12);
      end
      chk("basic_peak", peak, 1);

      // Gaps and phase on B
      logb.delete();
      for (int k = 1; k <= 6; k++) begin
         sendb(1'b1, 8'(k), 1'b1);
         sendb(1'b0, 8'h00, 1'b1);
      end
      repeat (2) sendb(1'b0, 8'h00, 1'b1);
      chk("phase_count", logb.size(), 2);
      if (logb.size() == 2) begin
         chk("phase_out0", logb[0], 8'h03);
         chk("phase_out1", logb[1], 8'h06);
      end

      // Backpressure and overflow on A
      pulse_reset();
      loga.delete();
      for (int k = 0; k < 10; k++) begin
         senda(1'b1, 8'(k), 1'b0);
         if (k == 7) begin
            chk("bp_level_full", a_lvl, 3'd4);
            chk("bp_ovf_before", a_of, 1'b0);
         end
         if (k == 8) begin
            chk("bp_ovf_set", a_of, 1'b1);
            chk("bp_head", a_dout, 8'h00);
         end
      end
      repeat (6) senda(1'b0, 8'h00, 1'b1);
      exp4 = '{8'h00, 8'h02, 8'h04, 8'h06};
      chk("bp_count", loga.size(), 4);
      if (loga.size() == 4)
         for (int i = 0; i < 4; i++) chk("bp_drain", loga[i], exp4[i]);
      chk("bp_level_empty", a_lvl, 3'd0);
      chk("bp_ovf_sticky", a_of, 1'b1);

      // Full FIFO with simultaneous push and pop
      pulse_reset();
      loga.delete();
      for (int k = 0; k < 8; k++) senda(1'b1, 8'h20 + 8'(k), 1'b0);
      chk("fp_level_full", a_lvl, 3'd4);
      senda(1'b1, 8'h28, 1'b1);
      chk("fp_level_kept", a_lvl, 3'd4);
      chk("fp_ovf", a_of, 1'b0);
      chk("fp_head", a_dout, 8'h22);
      repeat (6) senda(1'b0, 8'h00, 1'b1);
      exp5 = '{8'h20, 8'h22, 8'h24, 8'h26, 8'h28};
      chk("fp_count", loga.size(), 5);
      if (loga.size() == 5)
         for (int i = 0; i < 5; i++) chk("fp_drain", loga[i], exp5[i]);

      // Reset mid-stream
      pulse_reset();
      for (int k = 0; k < 6; k++) senda(1'b1, 8'h30 + 8'(k), 1'b0);
      chk("mr_level", a_lvl, 3'd3);
      pulse_reset();
      chk("mr_level_clr", a_lvl, 3'd0);
      chk("mr_valid_clr", a_ov, 1'b0);
      chk("mr_data_clr", a_dout, 8'h00);
      senda(1'b1, 8'h55, 1'b0);
      chk("mr_valid", a_ov, 1'b1);
      chk("mr_data", a_dout, 8'h55);
      chk("mr_level1", a_lvl, 3'd1);
      senda(1'b0, 8'h00, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Downstream stage of the hsFIR filter. Consumes the filtered 8-bit sample stream and keeps every DECIM-th sample, i.e. it decimates the stream.
- Kept samples are buffered in a small FIFO and presented on a valid/ready output interface for the next consumer.
- Dropped samples caused by backpressure are flagged with a sticky overflow indicator.

Parameters:
- DATA_W, 8: sample width in bits; matches the hsFIR output.
- DECIM, 2: decimation factor. Legal range 1..16. 1 means pass-through with buffering.
- PHASE, 0: index of the kept sample within each DECIM group. Legal range 0..DECIM-1.
- FIFO_DEPTH, 4: number of FIFO entries. Power of 2, minimum 2.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_reset_n  input  1  synchronous, active-low reset.
- i_data  input  DATA_W  filtered sample from hsFIR.
- i_valid  input  1  i_data is a new sample this cycle.
- o_data  output  DATA_W  FIFO head sample.
- o_valid  output  1  o_data holds a valid sample.
- i_ready  input  1  downstream accepts o_data this cycle.
- o_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_overflow  output  1  sticky flag: a kept sample was dropped.

Behaviour:
- Reset: one clock is sufficient. All state is evaluated at the clock edge while i_reset_n=0.
  - Reset values: o_valid=0, o_data=0, o_level=0, o_overflow=0.
  - Phase counter and read/write pointers are cleared to 0.
  - Reset mid-operation discards all FIFO contents. The first i_valid sample after reset has index 0.
- Phase counter:
  - Advances only on cycles with i_valid=1; wraps from DECIM-1 to 0.
  - Gaps in i_valid do not advance it.
  - A sample is kept when i_valid=1 and the counter equals PHASE, evaluated before the increment.
  - When DECIM=1, every valid sample is kept.
- Pop: occurs when o_valid=1 and i_ready=1 at the clock edge. The head advances and the next entry appears in the following cycle.
- Push: a kept sample is written to the FIFO when either:
  - level < FIFO_DEPTH, or
  - level == FIFO_DEPTH and a pop occurs in the same cycle (simultaneous write/read when full is allowed).
- Drop: a kept sample arriving when level == FIFO_DEPTH with no pop in that cycle.
  - The sample is discarded and FIFO contents are unchanged.
  - o_overflow is set to 1 on the next cycle and stays 1 until reset.
- Simultaneous push and pop: o_level is unchanged. When empty, push-only increments o_level and there is no pop.
- Empty FIFO: i_ready is ignored and o_level never underflows.
- Output signals:
  - o_valid = (o_level != 0).
  - o_data = head entry when o_valid=1, otherwise forced to 0.
  - o_data and o_valid hold stable while o_valid=1 and i_ready=0.
- Latency: a kept sample accepted into an empty FIFO at edge t gives o_valid=1 with that data in the cycle after edge t (1 cycle).
- Pointers: log2(FIFO_DEPTH)-bit read/write pointers wrap modulo FIFO_DEPTH. Ordering is strict FIFO.
- Data is stored unmodified: no arithmetic, no width change.
- Throughput: with i_ready held at 1, one output per DECIM valid inputs; the FIFO never overflows.

Test Plan:
- Reset: hold i_reset_n=0 for 3 cycles with i_valid=1, i_data=0xAA -> o_valid=0, o_data=0x00, o_level=0, o_overflow=0 throughout.
- Basic decimation: DECIM=2, PHASE=0, i_ready=1; back-to-back i_data 0x10,0x11,0x12,0x13 -> o_valid pulses carry 0x10 then 0x12, each 1 cycle after its input. 0x11 and 0x13 never appear; o_level peaks at 1.
- Valid gaps and phase: DECIM=3, PHASE=2, i_ready=1; samples 0x01..0x06 with 1-cycle idle gaps (i_valid=0) between them -> outputs 0x03 then 0x06 only.
- Backpressure/overflow: DECIM=2, FIFO_DEPTH=4, i_ready=0; samples 0x00..0x09 -> 0x00,0x02,0x04,0x06 stored, o_level=4. 0x08 is dropped and o_overflow=1 the cycle after. Then i_ready=1 -> drains 0x00,0x02,0x04,0x06 in order; o_level reaches 0; o_overflow stays 1.
- Full with simultaneous pop: fill 4 entries (0x20,0x22,0x24,0x26), then assert i_ready=1 in the same cycle kept sample 0x28 arrives -> o_level stays 4, o_overflow=0. The drain sequence is 0x22,0x24,0x26,0x28 after 0x20.
- Reset mid-stream: DECIM=2; store 3 samples, pulse i_reset_n=0 for 1 cycle -> o_level=0, o_valid=0. The next sample 0x55 (index 0) is kept and appears 1 cycle later.
